// File: rtl/im_loader.sv
// -----------------------------------------------------------------------------
// im_loader -- loads a program into instruction memory from a byte stream.
//
// After an accepted start it captures base_addr and word_count. It then
// assembles incoming bytes, most-significant byte first, into 32-bit words.
// Each completed word is written to consecutive word addresses with a
// one-cycle wr_en strobe. The write address wraps modulo 2^ADDR_W.
//
// Ports:
//   CLK         single clock, rising edge
//   RST_F       asynchronous active-low reset
//   start       one-cycle load request, sampled only while idle
//   base_addr   first word address written (captured on accepted start)
//   word_count  number of 32-bit words to load (captured on accepted start)
//   rx_valid    byte available on rx_data
//   rx_data     program byte stream, MSB of each word first
//   rx_ready    byte accepted when rx_valid && rx_ready at a rising edge
//   wr_en       one-cycle instruction-memory write strobe
//   wr_addr     word address for the write
//   wr_data     assembled instruction word
//   busy        high from accepted start until return to idle
//   done        one-cycle pulse when the load completes
//   csum        running XOR of all written words
//
// Optional feature macro: IM_LOADER_CHECKSUM_EN
//   defined   -> csum clears on accepted start and XORs in each written word
//   undefined -> csum is constant zero and no checksum register exists
// -----------------------------------------------------------------------------
module im_loader #(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              CLK,
  input  logic              RST_F,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       word_count,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic [31:0]       csum
);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    WRITE,
    FINISH
  } state_t;

  state_t      state;
  logic [15:0] remaining;
  logic [1:0]  byte_cnt;
  // Only the first three bytes are held here; the fourth goes straight into
  // wr_data together with them.
  logic [23:0] word;

  always_ff @(posedge CLK or negedge RST_F) begin
    if (!RST_F) begin
      state     <= IDLE;
      remaining <= '0;
      byte_cnt  <= '0;
      word      <= '0;
      rx_ready  <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy      <= 1'b1;
            wr_addr   <= base_addr;
            remaining <= word_count;
            byte_cnt  <= '0;
            if (word_count == '0) begin
              state <= FINISH;
              done  <= 1'b1;
            end else begin
              state    <= COLLECT;
              rx_ready <= 1'b1;
            end
          end
        end

        COLLECT: begin
          // rx_ready is always high in this state, so rx_valid alone marks a
          // transfer.
          if (rx_valid) begin
            word     <= {word[15:0], rx_data};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              wr_data  <= {word, rx_data};
              wr_en    <= 1'b1;
              rx_ready <= 1'b0;
              state    <= WRITE;
            end
          end
        end

        WRITE: begin
          wr_en     <= 1'b0;
          wr_addr   <= wr_addr + 1'b1;
          remaining <= remaining - 16'd1;
          if (remaining == 16'd1) begin
            state <= FINISH;
            done  <= 1'b1;
          end else begin
            state    <= COLLECT;
            rx_ready <= 1'b1;
          end
        end

        FINISH: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef IM_LOADER_CHECKSUM_EN
  always_ff @(posedge CLK or negedge RST_F) begin
    if (!RST_F) begin
      csum <= '0;
    end else if (state == IDLE && start) begin
      csum <= '0;
    end else if (state == WRITE) begin
      csum <= csum ^ wr_data;
    end
  end
`else
  assign csum = '0;
`endif

endmodule
